// File: rtl/ft_bus_scheduler.sv
// FT600 synchronous-FIFO bus scheduler: RX/TX burst sequencing, round-robin arbitration, turnaround gap.
// Optional per-direction word counters are enabled with FT_SCHED_STATS_EN.
module ft_bus_scheduler #(
  parameter int unsigned MAX_BURST   = 1024,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                               clk_ftdi,
  input  logic                               rst,
  input  logic                               rxf_n,
  input  logic                               txe_n,
  input  logic                               rx_space_ok,
  input  logic                               tx_avail,
  output logic                               oe_n,
  output logic                               rd_n,
  output logic                               wr_n,
  output logic                               bus_drive,
  output logic                               rx_wr_en,
  output logic                               tx_rd_en,
  output logic [1:0]                         dir,
  output logic [$clog2(MAX_BURST+1)-1:0]     burst_cnt
`ifdef FT_SCHED_STATS_EN
  ,
  output logic [31:0]                        rx_words,
  output logic [31:0]                        tx_words
`endif
);

  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    RX_OE = 5'b00010,
    RX_RD = 5'b00100,
    TX_WR = 5'b01000,
    TURN  = 5'b10000
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    burst_cnt_d;
  logic [TURN_W-1:0]   turn_cnt, turn_cnt_d;
  logic                last_tx, last_tx_d;
  logic                rx_elig, tx_elig;
  logic [SUM_W-1:0]    rx_sum, tx_sum;

  // Bus pins decode straight from the one-hot state register.
  assign oe_n      = !((state == RX_OE) || (state == RX_RD));
  assign rd_n      = (state != RX_RD);
  assign bus_drive = (state == TX_WR);
  assign dir       = {(state == TX_WR), ((state == RX_OE) || (state == RX_RD))};

  always_ff @(posedge clk_ftdi) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      turn_cnt  <= '0;
      last_tx   <= 1'b1;
    end else begin
      state     <= state_d;
      burst_cnt <= burst_cnt_d;
      turn_cnt  <= turn_cnt_d;
      last_tx   <= last_tx_d;
    end
  end

  // Next state, counters and the combinational FIFO/strobe terms.
  always_comb begin
    state_d     = state;
    burst_cnt_d = burst_cnt;
    turn_cnt_d  = turn_cnt;
    last_tx_d   = last_tx;
    rx_elig     = !rxf_n && rx_space_ok;
    tx_elig     = !txe_n && tx_avail;
    rx_wr_en    = !rst && (state == RX_RD) && rx_elig;
    tx_rd_en    = !rst && (state == TX_WR) && tx_elig;
    wr_n        = !tx_rd_en;
    rx_sum      = SUM_W'(burst_cnt) + SUM_W'(rx_wr_en);
    tx_sum      = SUM_W'(burst_cnt) + SUM_W'(tx_rd_en);

    case (state)
      IDLE: begin
        // On contention the direction not served last wins.
        if (rx_elig && (!tx_elig || last_tx)) begin
          state_d     = RX_OE;
          last_tx_d   = 1'b0;
          burst_cnt_d = '0;
        end else if (tx_elig) begin
          state_d     = TX_WR;
          last_tx_d   = 1'b1;
          burst_cnt_d = '0;
        end
      end
      RX_OE: state_d = RX_RD;
      RX_RD: begin
        burst_cnt_d = rx_sum[CNT_W-1:0];
        if (!rx_elig || (rx_sum == SUM_W'(MAX_BURST))) begin
          state_d    = TURN;
          turn_cnt_d = '0;
        end
      end
      TX_WR: begin
        burst_cnt_d = tx_sum[CNT_W-1:0];
        if (!tx_elig || (tx_sum == SUM_W'(MAX_BURST))) begin
          state_d    = TURN;
          turn_cnt_d = '0;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) state_d = IDLE;
        else turn_cnt_d = turn_cnt + TURN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FT_SCHED_STATS_EN
  // Free-running word counters, wrapping modulo 2^32.
  always_ff @(posedge clk_ftdi) begin
    if (rst) begin
      rx_words <= '0;
      tx_words <= '0;
    end else begin
      rx_words <= rx_words + 32'(rx_wr_en);
      tx_words <= tx_words + 32'(tx_rd_en);
    end
  end
`endif

endmodule
